alu_rx_sequencer: RTL and testbench

Upstream/downstream glue for the ALU: collects three bytes from a UART receiver (operand A, operand B, opcode), presents them as stable registered inputs to the combinational ALU, and captures the ALU result after one settle cycle. The captured result is then handed to a UART transmitter with a start/done handshake. It sits between the UART RX/TX pair and the ALU `i_A`/`i_B`/`i_Op`/`o_res` ports.

---
 rtl/alu_rx_sequencer_if.sv | 49 ++++
 rtl/alu_rx_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_rx_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rx_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_rx_sequencer_if
//
// Purpose: bundles the UART RX, ALU and UART TX facing signals of
// alu_rx_sequencer so that they travel as a single port.
//
// Signals (direction as seen by the sequencer, modport "slave"):
//   i_rx_data  in  N_BITS  received byte, valid while i_rx_done = 1
//   i_rx_done  in  1       one-cycle pulse, byte received
//   o_A        out N_BITS  registered operand A to the ALU
//   o_B        out N_BITS  registered operand B to the ALU
//   o_Op       out N_OP    registered opcode to the ALU
//   i_alu_res  in  N_BITS  ALU result (combinational from o_A/o_B/o_Op)
//   o_tx_data  out N_BITS  captured result to the transmitter
//   o_tx_start out 1       one-cycle transmit request
//   i_tx_done  in  1       one-cycle pulse, transmitter finished
//   o_busy     out 1       high whenever the sequencer is not idle
//   o_overrun  out 1       one-cycle pulse, received byte dropped
//   o_timeout  out 1       one-cycle pulse, frame aborted by timeout
//
// Modport "master" is the environment side (UART pair + ALU).
// -----------------------------------------------------------------------------
interface alu_rx_sequencer_if #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
);
    logic [N_BITS-1:0] i_rx_data;
    logic              i_rx_done;
    logic [N_BITS-1:0] o_A;
    logic [N_BITS-1:0] o_B;
    logic [N_OP-1:0]   o_Op;
    logic [N_BITS-1:0] i_alu_res;
    logic [N_BITS-1:0] o_tx_data;
    logic              o_tx_start;
    logic              i_tx_done;
    logic              o_busy;
    logic              o_overrun;
    logic              o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_res, i_tx_done,
        output o_A, o_B, o_Op, o_tx_data, o_tx_start, o_busy, o_overrun, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_res, i_tx_done,
        input  o_A, o_B, o_Op, o_tx_data, o_tx_start, o_busy, o_overrun, o_timeout
    );
endinterface

// File: rtl/alu_rx_sequencer.sv
// -----------------------------------------------------------------------------
// alu_rx_sequencer
//
// Purpose: collects three bytes from a UART receiver (operand A, operand B,
// opcode), holds them as stable registered ALU inputs, captures the ALU result
// after one settle cycle and hands it to a UART transmitter with a start/done
// handshake.
//
// Parameters:
//   N_BITS          operand, result and UART byte width
//   N_OP            opcode width (low N_OP bits of the third byte)
//   TIMEOUT_CYCLES  inter-byte timeout, only used with ALU_SEQ_TIMEOUT_EN
//
// Ports:
//   i_clk    in  system clock, rising edge
//   i_rst_n  in  asynchronous active-low reset
//   bus      alu_rx_sequencer_if.slave (RX, ALU and TX signals)
//
// Build option:
//   ALU_SEQ_TIMEOUT_EN  when defined, a frame stuck waiting for B or the
//                       opcode for TIMEOUT_CYCLES cycles is abandoned and
//                       o_timeout pulses. Otherwise o_timeout is tied to 0
//                       and the FSM waits indefinitely.
// -----------------------------------------------------------------------------
module alu_rx_sequencer #(
    parameter int N_BITS         = 8,
    parameter int N_OP           = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    alu_rx_sequencer_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    // Catch configurations that cannot work at elaboration time.
    if (N_OP > N_BITS) begin : g_bad_op_width
        $error("alu_rx_sequencer: N_OP must not exceed N_BITS");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("alu_rx_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;
`else
    assign bus.o_timeout = 1'b0;
`endif

    // Single-process FSM: every output is a register updated together with
    // the state, so the ALU operands and the TX handshake are glitch-free.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            bus.o_A        <= '0;
            bus.o_B        <= '0;
            bus.o_Op       <= '0;
            bus.o_tx_data  <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_overrun  <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            bus.o_timeout  <= 1'b0;
            idle_cnt       <= '0;
`endif
        end else begin
            // Pulse outputs default low; the states below raise them for
            // exactly one cycle.
            bus.o_tx_start <= 1'b0;
            bus.o_overrun  <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            bus.o_timeout  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.i_rx_done) begin
                        bus.o_A    <= bus.i_rx_data;
                        bus.o_busy <= 1'b1;
                        state      <= WAIT_B;
`ifdef ALU_SEQ_TIMEOUT_EN
                        idle_cnt   <= '0;
`endif
                    end
                end

                WAIT_B, WAIT_OP: begin
                    if (bus.i_rx_done) begin
                        // A byte arriving on the expiry edge still counts.
                        if (state == WAIT_B) begin
                            bus.o_B <= bus.i_rx_data;
                            state   <= WAIT_OP;
                        end else begin
                            // Upper byte bits are not part of the opcode.
                            bus.o_Op <= bus.i_rx_data[N_OP-1:0];
                            state    <= EXEC;
                        end
`ifdef ALU_SEQ_TIMEOUT_EN
                        idle_cnt <= '0;
                    end else if (idle_cnt == CNT_LAST) begin
                        // Abandon the frame; operand registers keep their
                        // values since the ALU output is not consumed.
                        bus.o_timeout <= 1'b1;
                        bus.o_busy    <= 1'b0;
                        idle_cnt      <= '0;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
`endif
                    end
                end

                EXEC: begin
                    // The operands have been stable for a full cycle, so the
                    // combinational ALU result has settled by this edge.
                    bus.o_tx_data  <= bus.i_alu_res;
                    bus.o_tx_start <= 1'b1;
                    bus.o_overrun  <= bus.i_rx_done;
                    state          <= SEND;
                end

                SEND: begin
                    // i_tx_done cannot belong to this frame yet: ignore it.
                    bus.o_overrun <= bus.i_rx_done;
                    state         <= WAIT_TX;
                end

                WAIT_TX: begin
                    bus.o_overrun <= bus.i_rx_done;
                    if (bus.i_tx_done) begin
                        bus.o_busy <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_rx_sequencer
//
// Directed bench for alu_rx_sequencer. A small ALU stub drives i_alu_res from
// the DUT operands. Each frame pushes its hand-computed expected result into a
// scoreboard queue; an independent monitor pops and compares whenever the DUT
// raises o_tx_start. Handshake timing, overrun, reset and timeout behaviour
// are checked inline by the stimulus process.
// -----------------------------------------------------------------------------
module tb_alu_rx_sequencer;

    localparam int N_BITS = 8;
    localparam int N_OP   = 6;
    localparam int TMO    = 16;

    typedef struct {
        logic [N_OP-1:0]   op;
        logic [N_BITS-1:0] res;
    } sb_entry_t;

    logic clk;
    logic rst_n;

    alu_rx_sequencer_if #(.N_BITS(N_BITS), .N_OP(N_OP)) bus ();

    alu_rx_sequencer #(
        .N_BITS        (N_BITS),
        .N_OP          (N_OP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub (MIPS-style function codes).
    always_comb begin
        case (bus.o_Op)
            6'h20:   bus.i_alu_res = bus.o_A + bus.o_B;
            6'h22:   bus.i_alu_res = bus.o_A - bus.o_B;
            6'h23:   bus.i_alu_res = bus.o_A - bus.o_B;
            6'h24:   bus.i_alu_res = bus.o_A & bus.o_B;
            6'h25:   bus.i_alu_res = bus.o_A | bus.o_B;
            6'h26:   bus.i_alu_res = bus.o_A ^ bus.o_B;
            6'h27:   bus.i_alu_res = ~(bus.o_A | bus.o_B);
            default: bus.i_alu_res = '0;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;

    sb_entry_t sb[$];
    sb_entry_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each o_tx_start cycle must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n && bus.o_tx_start) begin
            if (sb.size() == 0) begin
                check("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_tx_data", 32'(bus.o_tx_data), 32'(mon_e.res));
                check("sb_op", 32'(bus.o_Op), 32'(mon_e.op));
            end
        end
    end

    // Called at a negedge; the byte is sampled by the next rising edge and
    // the task returns at the following negedge.
    task automatic send_byte(input logic [N_BITS-1:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input logic [7:0] res);
        logic [7:0] ob;
        sb_entry_t  e;
        ob = opb;
        send_byte(a);
        check("o_A", 32'(bus.o_A), 32'(a));
        check("busy_wait_b", 32'(bus.o_busy), 32'd1);
        send_byte(b);
        check("o_B", 32'(bus.o_B), 32'(b));
        e.op  = ob[N_OP-1:0];
        e.res = res;
        sb.push_back(e);
        send_byte(opb);
        check("o_Op", 32'(bus.o_Op), 32'(ob[N_OP-1:0]));
        check("tx_start_exec", 32'(bus.o_tx_start), 32'd0);
        @(negedge clk);
        check("tx_start_send", 32'(bus.o_tx_start), 32'd1);
        @(negedge clk);
        check("tx_start_wait_tx", 32'(bus.o_tx_start), 32'd0);
        check("busy_wait_tx", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic finish_tx(input int delay);
        repeat (delay) @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        check("busy_after_tx_done", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},        32'(bus.o_A), 32'd0);
        check({tag, "_B"},        32'(bus.o_B), 32'd0);
        check({tag, "_Op"},       32'(bus.o_Op), 32'd0);
        check({tag, "_tx_data"},  32'(bus.o_tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
        check({tag, "_busy"},     32'(bus.o_busy), 32'd0);
        check({tag, "_overrun"},  32'(bus.o_overrun), 32'd0);
        check({tag, "_timeout"},  32'(bus.o_timeout), 32'd0);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  waited;
        bit  stay_ok;

        rst_n         = 1'b0;
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ADD: 3 + 3 = 6, opcode 6'b100000.
        do_frame(8'h03, 8'h03, 8'h20, 8'h06);
        finish_tx(3);

        // SUB: 6 - 2 = 4; then a stray byte while waiting for TX completion.
        do_frame(8'h06, 8'h02, 8'h22, 8'h04);
        send_byte(8'h0F);
        check("overrun_pulse", 32'(bus.o_overrun), 32'd1);
        check("overrun_keeps_A", 32'(bus.o_A), 32'h06);
        check("overrun_busy", 32'(bus.o_busy), 32'd1);
        @(negedge clk);
        check("overrun_one_cycle", 32'(bus.o_overrun), 32'd0);
        finish_tx(2);

        // NOR: ~(0x0F | 0x04) = 0xF0, A accepted on the edge right after
        // the tx_done edge.
        do_frame(8'h0F, 8'h04, 8'h27, 8'hF0);
        finish_tx(1);

        // Opcode 0xE3 truncates to 6'b100011 (stub: A - B = 9 - 4 = 5).
        do_frame(8'h09, 8'h04, 8'hE3, 8'h05);
        finish_tx(0);

        // Asynchronous reset in WAIT_OP discards the partial frame.
        send_byte(8'h05);
        send_byte(8'h02);
        check("pre_reset_busy", 32'(bus.o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_frame(8'h01, 8'h02, 8'h20, 8'h03);
        finish_tx(2);

        // Inter-byte timeout behaviour.
        send_byte(8'h07);
`ifdef ALU_SEQ_TIMEOUT_EN
        waited = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.o_timeout) begin
                waited = i;
                break;
            end
        end
        check("timeout_cycles", 32'(waited), 32'(TMO));
        check("timeout_idle", 32'(bus.o_busy), 32'd0);
        check("timeout_keeps_A", 32'(bus.o_A), 32'h07);
        @(negedge clk);
        check("timeout_one_cycle", 32'(bus.o_timeout), 32'd0);
        do_frame(8'h07, 8'h01, 8'h20, 8'h08);
        finish_tx(1);
`else
        stay_ok = 1'b1;
        waited  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (!bus.o_busy || bus.o_timeout) stay_ok = 1'b0;
        end
        check("stay_in_wait_b", 32'(stay_ok), 32'd1);
        begin
            sb_entry_t e;
            e.op  = 6'h20;
            e.res = 8'h08;
            sb.push_back(e);
        end
        send_byte(8'h01);
        check("late_B", 32'(bus.o_B), 32'h01);
        send_byte(8'h20);
        @(negedge clk);
        check("late_tx_start", 32'(bus.o_tx_start), 32'd1);
        finish_tx(2);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
